// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the shared 7-segment display arbiter.
//   owner_t    : who currently owns the display (IDLE, OWN_A, OWN_B)
//   SEG_*      : 7-bit segment patterns, bit order {a,b,c,d,e,f,g}, active-high
//   SEG_DASH   : shown for non-BCD nibbles (10..15)
//   SEG_BLANK  : all segments off
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------
// seg_decoder
// Combinational BCD nibble to 7-segment pattern; non-BCD values show a dash.
// Ports:
//   nibble  in  4  digit value
//   seg     out 7  segment pattern {a,b,c,d,e,f,g}, active-high
// ---------------------------------------------------------------------------
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Shares one multiplexed 7-segment display between two requesters A and B.
// A prescaler produces a digit tick, the scan index walks the digits, and a
// round-robin ownership FSM (evaluated only at frame boundaries) decides who
// owns the display, honouring a minimum hold before voluntary release and a
// maximum hold after which a waiting requester preempts. The owner's data is
// latched once per frame so mid-frame changes never tear the display.
// Ports:
//   clk     in  1   system clock
//   rstn    in  1   synchronous reset, active-low
//   req_a   in  1   requester A wants the display (level)
//   data_a  in  32  A digits, nibble k = digit k, BCD
//   gnt_a   out 1   A owns the display
//   req_b   in  1   requester B wants the display (level)
//   data_b  in  32  B digits, same format
//   gnt_b   out 1   B owns the display
//   seg     out 7   segments {a,b,c,d,e,f,g}, active-high
//   sel     out 8   digit select, one-hot, bit k = digit k
//   frame   out 1   one-cycle pulse after each frame-boundary tick
// Build option:
//   SEG_LZ_BLANK_EN  blank digits above the highest nonzero latched nibble
//                    (digit 0 always shown, nibbles >= 10 count as nonzero)
// ---------------------------------------------------------------------------
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 8,
    parameter int MIN_HOLD   = 125,
    parameter int MAX_HOLD   = 500
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_a,
    input  logic [31:0] data_a,
    output logic        gnt_a,
    input  logic        req_b,
    input  logic [31:0] data_b,
    output logic        gnt_b,
    output logic [6:0]  seg,
    output logic [7:0]  sel,
    output logic        frame
);

    localparam int         CNT_W    = $clog2(CLK_DIV);
    localparam int         HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic              boundary;
    logic [2:0]        idx;
    logic [2:0]        next_idx;
    owner_t            state;
    owner_t            state_d;
    owner_t            rr_ptr;
    logic              grant;
    logic [HOLD_W-1:0] hold;
    logic [31:0]       shadow;
    logic [31:0]       shadow_d;
    logic [3:0]        nibble;
    logic [6:0]        dec_seg;
    logic              blank;
    logic [6:0]        seg_d;

    assign tick     = (cnt == CNT_W'(CLK_DIV - 1));
    assign boundary = tick && (idx == IDX_LAST);
    assign next_idx = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= next_idx;
            end
        end
    end

    // Ownership state register plus the hold counter and round-robin pointer
    // that travel with it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            hold   <= '0;
            rr_ptr <= OWN_A;
        end else begin
            state <= state_d;
            if (grant) begin
                hold   <= '0;
                rr_ptr <= (state_d == OWN_A) ? OWN_B : OWN_A;
            end else if (boundary && (hold != HOLD_W'(MAX_HOLD))) begin
                hold <= hold + 1'b1;
            end
        end
    end

    // Preemption is checked before voluntary release so a starving requester
    // wins even while the owner still asserts its request.
    always_comb begin
        state_d = state;
        if (boundary) begin
            case (state)
                IDLE: begin
                    if (req_a && req_b) state_d = rr_ptr;
                    else if (req_a)     state_d = OWN_A;
                    else if (req_b)     state_d = OWN_B;
                end
                OWN_A: begin
                    if (req_b && (hold >= HOLD_W'(MAX_HOLD)))
                        state_d = OWN_B;
                    else if (!req_a && (hold >= HOLD_W'(MIN_HOLD)))
                        state_d = req_b ? OWN_B : IDLE;
                end
                OWN_B: begin
                    if (req_a && (hold >= HOLD_W'(MAX_HOLD)))
                        state_d = OWN_A;
                    else if (!req_b && (hold >= HOLD_W'(MIN_HOLD)))
                        state_d = req_a ? OWN_A : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Grants come straight from the state flop, so the handoff is a single
    // edge with no idle frame and the two grants can never overlap.
    always_comb begin
        gnt_a = (state == OWN_A);
        gnt_b = (state == OWN_B);
        grant = boundary && (state_d != IDLE) && (state_d != state);
    end

    // shadow_d is what the display will hold after this edge; the first digit
    // of a new frame is decoded from it so it already shows the new owner.
    always_comb begin
        shadow_d = shadow;
        if (boundary) begin
            case (state_d)
                OWN_A:   shadow_d = data_a;
                OWN_B:   shadow_d = data_b;
                default: shadow_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow <= '0;
        end else begin
            shadow <= shadow_d;
        end
    end

    assign nibble = shadow_d[{next_idx, 2'b00} +: 4];

    seg_decoder u_decoder (
        .nibble (nibble),
        .seg    (dec_seg)
    );

`ifdef SEG_LZ_BLANK_EN
    logic [2:0] top_nz;

    // Highest scanned digit holding a nonzero nibble; digit 0 is the floor.
    always_comb begin
        top_nz = 3'd0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (shadow_d[k*4 +: 4] != 4'd0) begin
                top_nz = 3'(k);
            end
        end
        blank = (next_idx > top_nz);
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_d = ((state_d == IDLE) || blank) ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            seg   <= SEG_BLANK;
            sel   <= 8'd0;
            frame <= 1'b0;
        end else begin
            frame <= boundary;
            if (tick) begin
                seg <= seg_d;
                sel <= (state_d == IDLE) ? 8'd0 : (8'd1 << next_idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_display_arbiter
// Directed, table-driven bench for seg_display_arbiter with small parameters
// (CLK_DIV=4, NUM_DIGITS=3, MIN_HOLD=2, MAX_HOLD=4). Expected segment values
// follow the SEG_LZ_BLANK_EN build option.
// ---------------------------------------------------------------------------
module tb_seg_display_arbiter;

    localparam int CLK_DIV    = 4;
    localparam int NUM_DIGITS = 3;
    localparam int MIN_HOLD   = 2;
    localparam int MAX_HOLD   = 4;
    localparam int FRAME_CYC  = CLK_DIV * NUM_DIGITS;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SD = 7'b0000001;

    logic        clk;
    logic        rstn;
    logic        req_a;
    logic [31:0] data_a;
    logic        gnt_a;
    logic        req_b;
    logic [31:0] data_b;
    logic        gnt_b;
    logic [6:0]  seg;
    logic [7:0]  sel;
    logic        frame;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [6:0]  seg0;
        logic [6:0]  seg1;
        logic [6:0]  seg2;
        logic [2:0]  lz_mask;
    } vec_t;

    vec_t vectors [7];

    seg_display_arbiter #(
        .CLK_DIV    (CLK_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .MIN_HOLD   (MIN_HOLD),
        .MAX_HOLD   (MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req_a  (req_a),
        .data_a (data_a),
        .gnt_a  (gnt_a),
        .req_b  (req_b),
        .data_b (data_b),
        .gnt_b  (gnt_b),
        .seg    (seg),
        .sel    (sel),
        .frame  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The two grants must never be high together.
    always @(negedge clk) begin
        checks++;
        if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
            errors++;
            $display("[TB] FAIL both_gnt at %0t: gnt_a=%b gnt_b=%b required not both 1", $time, gnt_a, gnt_b);
        end
    end

    task automatic applyStimulus(input logic r, input logic ra, input logic [31:0] da,
                                 input logic rb, input logic [31:0] db);
        rstn   = r;
        req_a  = ra;
        data_a = da;
        req_b  = rb;
        data_b = db;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Advances to the sample point just after the next frame pulse.
    task automatic waitFrame(output int edges);
        edges = 0;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (frame === 1'b1) return;
        end
        checkOutput("frame_timeout", 32'(frame), 32'd1);
    endtask

    function automatic logic [6:0] expSeg(input logic [6:0] s, input logic blank);
`ifdef SEG_LZ_BLANK_EN
        return blank ? 7'b0000000 : s;
`else
        return blank ? s : s;
`endif
    endfunction

    // Called at the frame sample point; scribbles on data_a after digit 0 to
    // show that mid-frame changes stay invisible.
    task automatic checkFrame(input vec_t v);
        checkOutput("sel_d0", 32'(sel), 32'h1);
        checkOutput("seg_d0", 32'(seg), 32'(expSeg(v.seg0, v.lz_mask[0])));
        data_a = 32'h8888_8888;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        checkOutput("sel_d1", 32'(sel), 32'h2);
        checkOutput("seg_d1", 32'(seg), 32'(expSeg(v.seg1, v.lz_mask[1])));
        repeat (CLK_DIV) @(posedge clk);
        #1;
        checkOutput("sel_d2", 32'(sel), 32'h4);
        checkOutput("seg_d2", 32'(seg), 32'(expSeg(v.seg2, v.lz_mask[2])));
    endtask

    task automatic holdReset(input logic ra, input logic [31:0] da, input logic rb, input logic [31:0] db);
        applyStimulus(1'b0, ra, da, rb, db);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        int n;

        vectors[0] = '{32'h0000_0087, S7, S8, S0, 3'b100};
        vectors[1] = '{32'h0000_00C0, S0, SD, S0, 3'b100};
        vectors[2] = '{32'h0000_0007, S7, S0, S0, 3'b110};
        vectors[3] = '{32'h0000_0000, S0, S0, S0, 3'b110};
        vectors[4] = '{32'h0000_0123, S3, S2, S1, 3'b000};
        vectors[5] = '{32'hABC0_0945, S5, S4, S9, 3'b000};
        vectors[6] = '{32'h0000_00F6, S6, SD, S0, 3'b100};

        // A alone from reset: grant and first frame after exactly one frame.
        holdReset(1'b1, 32'h0000_0087, 1'b0, 32'h0);
        waitFrame(n);
        checkOutput("first_frame_edges", 32'(n), 32'(FRAME_CYC));
        checkOutput("gnt_a_first", 32'(gnt_a), 32'd1);
        checkOutput("gnt_b_first", 32'(gnt_b), 32'd0);
        checkFrame(vectors[0]);

        for (int i = 0; i < 7; i++) begin
            data_a = vectors[i].data;
            waitFrame(n);
            checkFrame(vectors[i]);
        end

        // Reset asserted mid-scan, held three cycles.
        applyStimulus(1'b0, 1'b1, 32'h0000_0087, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_seg", 32'(seg), 32'd0);
            checkOutput("rst_sel", 32'(sel), 32'd0);
            checkOutput("rst_gnt", 32'({gnt_a, gnt_b}), 32'd0);
            checkOutput("rst_frame", 32'(frame), 32'd0);
        end
        rstn = 1'b1;

        // A held, B raised right after A's grant: B preempts on the sixth
        // boundary, when A's hold counter reads MAX_HOLD.
        waitFrame(n);
        checkOutput("post_rst_edges", 32'(n), 32'(FRAME_CYC));
        checkOutput("pre_gnt_a", 32'(gnt_a), 32'd1);
        req_b  = 1'b1;
        data_b = 32'h0000_0321;
        for (int f = 2; f <= 6; f++) begin
            waitFrame(n);
            checkOutput("pre_gnt_a_f", 32'(gnt_a), (f < 6) ? 32'd1 : 32'd0);
            checkOutput("pre_gnt_b_f", 32'(gnt_b), (f < 6) ? 32'd0 : 32'd1);
        end
        checkOutput("pre_seg_b", 32'(seg), 32'(S1));

        // Both requesting from reset: A first, release to B with no gap,
        // then B releases to IDLE once its minimum hold is met.
        holdReset(1'b1, 32'h0000_0087, 1'b1, 32'h0000_0321);
        waitFrame(n);
        checkOutput("rr_gnt_a", 32'({gnt_a, gnt_b}), 32'b10);
        waitFrame(n);
        waitFrame(n);
        checkOutput("rr_gnt_a_f3", 32'({gnt_a, gnt_b}), 32'b10);
        req_a = 1'b0;
        waitFrame(n);
        checkOutput("handoff_b", 32'({gnt_a, gnt_b}), 32'b01);
        checkOutput("handoff_seg", 32'(seg), 32'(S1));
        req_b = 1'b0;
        waitFrame(n);
        checkOutput("b_min_hold_f5", 32'({gnt_a, gnt_b}), 32'b01);
        waitFrame(n);
        checkOutput("b_min_hold_f6", 32'({gnt_a, gnt_b}), 32'b01);
        waitFrame(n);
        checkOutput("idle_gnt", 32'({gnt_a, gnt_b}), 32'b00);
        checkOutput("idle_sel", 32'(sel), 32'd0);
        checkOutput("idle_seg", 32'(seg), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
